pipeline_stall_controller: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Merges the combinational load-use hazard flag, the ID-stage branch-taken flag and data-cache miss events into one consistent set of per-stage stall, flush and bubble controls.
- Runs a small FSM that freezes the pipeline across a multi-cycle cache refill (req/ack handshake), with a watchdog timeout.
- Keeps saturating stall and flush performance counters.

---
 rtl/pipeline_stall_controller_if.sv | 40 ++++
 rtl/pipeline_stall_controller.sv | 139 +++++++++++++
 tb/tb_pipeline_stall_controller.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stall_controller_if.sv
// Handshake and control bundle between the stall sequencer
// and the pipeline / data-cache refill logic.
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic             load_use_i;
  logic             branch_taken_i;
  logic             mem_access_i;
  logic             mem_miss_i;
  logic             mem_ack_i;
  logic             mem_req_o;
  logic             PC_Stall_o;
  logic             IF_ID_Stall_o;
  logic             IF_ID_Flush_o;
  logic             ID_EX_Bubble_o;
  logic             EX_MEM_Stall_o;
  logic             MEM_WB_Bubble_o;
  logic             timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  modport master (
    output start_i, load_use_i, branch_taken_i,
    output mem_access_i, mem_miss_i, mem_ack_i,
    input  mem_req_o, PC_Stall_o, IF_ID_Stall_o,
    input  IF_ID_Flush_o, ID_EX_Bubble_o,
    input  EX_MEM_Stall_o, MEM_WB_Bubble_o,
    input  timeout_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  start_i, load_use_i, branch_taken_i,
    input  mem_access_i, mem_miss_i, mem_ack_i,
    output mem_req_o, PC_Stall_o, IF_ID_Stall_o,
    output IF_ID_Flush_o, ID_EX_Bubble_o,
    output EX_MEM_Stall_o, MEM_WB_Bubble_o,
    output timeout_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer: hazard merge, cache-refill
// freeze FSM with watchdog, saturating perf counters.
module pipeline_stall_controller #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input logic                   clk_i,
  input logic                   rst_i,
  pipeline_stall_controller_if.slave bus
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_MISS   = 2'd1;
  localparam logic [1:0] S_REPLAY = 2'd2;
  localparam logic [1:0] S_ERR    = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             req_q, req_d;
  logic             tmo_q, tmo_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic pc_st, ifid_st, ifid_fl;
  logic idex_bub, exmem_st, memwb_bub;
  logic freeze;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    freeze  = 1'b0;
    pc_st     = 1'b0;
    ifid_st   = 1'b0;
    ifid_fl   = 1'b0;
    idex_bub  = 1'b0;
    exmem_st  = 1'b0;
    memwb_bub = 1'b0;
    unique case (state_q)
      S_RUN: begin
        if (!bus.start_i) begin
          pc_st    = 1'b1;
          ifid_st  = 1'b1;
          exmem_st = 1'b1;
        end else if (bus.mem_access_i && bus.mem_miss_i) begin
          freeze  = 1'b1;
          state_d = S_MISS;
          wait_d  = 8'd0;
        end else if (bus.load_use_i) begin
          pc_st    = 1'b1;
          ifid_st  = 1'b1;
          idex_bub = 1'b1;
        end else if (bus.branch_taken_i) begin
          ifid_fl = 1'b1;
        end
      end
      S_MISS: begin
        freeze = 1'b1;
        wait_d = wait_q + 8'd1;
        // Ack beats a timeout landing on the same cycle.
        if (bus.mem_ack_i) begin
          state_d = S_REPLAY;
          wait_d  = 8'd0;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERR;
        end
      end
      S_REPLAY: begin
        freeze  = 1'b1;
        state_d = S_RUN;
      end
      S_ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    if (freeze) begin
      pc_st     = 1'b1;
      ifid_st   = 1'b1;
      exmem_st  = 1'b1;
      memwb_bub = 1'b1;
    end
    // Reset forces every stage control low, independent of inputs.
    if (rst_i) begin
      pc_st     = 1'b0;
      ifid_st   = 1'b0;
      ifid_fl   = 1'b0;
      idex_bub  = 1'b0;
      exmem_st  = 1'b0;
      memwb_bub = 1'b0;
    end
  end

  always_comb begin
    req_d   = (state_d == S_MISS);
    tmo_d   = tmo_q | (state_d == S_ERR);
    stall_d = stall_q;
    flush_d = flush_q;
    if (pc_st && bus.start_i && (stall_q != '1)) begin
      stall_d = stall_q + 1'b1;
    end
    if (ifid_fl && (flush_q != '1)) begin
      flush_d = flush_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_RUN;
      wait_q  <= 8'd0;
      req_q   <= 1'b0;
      tmo_q   <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      req_q   <= req_d;
      tmo_q   <= tmo_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign bus.mem_req_o       = req_q;
  assign bus.timeout_o       = tmo_q;
  assign bus.stall_cnt_o     = stall_q;
  assign bus.flush_cnt_o     = flush_q;
  assign bus.PC_Stall_o      = pc_st;
  assign bus.IF_ID_Stall_o   = ifid_st;
  assign bus.IF_ID_Flush_o   = ifid_fl;
  assign bus.ID_EX_Bubble_o  = idex_bub;
  assign bus.EX_MEM_Stall_o  = exmem_st;
  assign bus.MEM_WB_Bubble_o = memwb_bub;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Bench for pipeline_stall_controller: two instances
// (TIMEOUT=8/CNT_W=4 and TIMEOUT=4/CNT_W=16) share stimulus.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic lu = 1'b0;
  logic br = 1'b0;
  logic acc = 1'b0;
  logic miss = 1'b0;
  logic ack = 1'b0;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.CNT_W(4))  ifa ();
  pipeline_stall_controller_if #(.CNT_W(16)) ifb ();

  assign ifa.start_i        = start;
  assign ifa.load_use_i     = lu;
  assign ifa.branch_taken_i = br;
  assign ifa.mem_access_i   = acc;
  assign ifa.mem_miss_i     = miss;
  assign ifa.mem_ack_i      = ack;
  assign ifb.start_i        = start;
  assign ifb.load_use_i     = lu;
  assign ifb.branch_taken_i = br;
  assign ifb.mem_access_i   = acc;
  assign ifb.mem_miss_i     = miss;
  assign ifb.mem_ack_i      = ack;

  pipeline_stall_controller #(.TIMEOUT(8), .CNT_W(4)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifa)
  );

  pipeline_stall_controller #(.TIMEOUT(4), .CNT_W(16)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (ifb)
  );

  // Reference model: -1 = not waiting, else cycles already waited.
  int wn [2] = '{-1, -1};
  bit rp [2] = '{0, 0};
  bit dd [2] = '{0, 0};
  int sc [2] = '{0, 0};
  int fc [2] = '{0, 0};
  int to [2] = '{8, 4};
  int mx [2] = '{15, 65535};

  // Bit order: pc, ifid_stall, ifid_flush, idex_bub, exmem, memwb
  function automatic logic [5:0] exp_ctl(int i);
    if (rst) return 6'b000000;
    if (wn[i] >= 0 || rp[i] || dd[i]) return 6'b110011;
    if (!start) return 6'b110010;
    if (acc && miss) return 6'b110011;
    if (lu) return 6'b110100;
    if (br) return 6'b001000;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] act_ctl(int i);
    if (i == 0)
      return {ifa.PC_Stall_o, ifa.IF_ID_Stall_o,
              ifa.IF_ID_Flush_o, ifa.ID_EX_Bubble_o,
              ifa.EX_MEM_Stall_o, ifa.MEM_WB_Bubble_o};
    return {ifb.PC_Stall_o, ifb.IF_ID_Stall_o,
            ifb.IF_ID_Flush_o, ifb.ID_EX_Bubble_o,
            ifb.EX_MEM_Stall_o, ifb.MEM_WB_Bubble_o};
  endfunction

  function automatic int act_req(int i);
    return (i == 0) ? int'(ifa.mem_req_o) : int'(ifb.mem_req_o);
  endfunction

  function automatic int act_tmo(int i);
    return (i == 0) ? int'(ifa.timeout_o) : int'(ifb.timeout_o);
  endfunction

  function automatic int act_sc(int i);
    return (i == 0) ? int'(ifa.stall_cnt_o) : int'(ifb.stall_cnt_o);
  endfunction

  function automatic int act_fc(int i);
    return (i == 0) ? int'(ifa.flush_cnt_o) : int'(ifb.flush_cnt_o);
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d @%0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        wn[i] <= -1;
        rp[i] <= 1'b0;
        dd[i] <= 1'b0;
        sc[i] <= 0;
        fc[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic logic [5:0] c = exp_ctl(i);
        if (c[5] && start && sc[i] < mx[i]) sc[i] <= sc[i] + 1;
        if (c[3] && fc[i] < mx[i]) fc[i] <= fc[i] + 1;
        if (wn[i] >= 0) begin
          if (ack) begin
            wn[i] <= -1;
            rp[i] <= 1'b1;
          end else if (wn[i] == to[i] - 1) begin
            wn[i] <= -1;
            dd[i] <= 1'b1;
          end else begin
            wn[i] <= wn[i] + 1;
          end
        end else if (rp[i]) begin
          rp[i] <= 1'b0;
        end else if (!dd[i] && start && acc && miss) begin
          wn[i] <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ctl%0d", i), int'(act_ctl(i)), int'(exp_ctl(i)));
      chk($sformatf("req%0d", i), act_req(i), int'(wn[i] >= 0));
      chk($sformatf("tmo%0d", i), act_tmo(i), int'(dd[i]));
      chk($sformatf("scnt%0d", i), act_sc(i), sc[i]);
      chk($sformatf("fcnt%0d", i), act_fc(i), fc[i]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    #1;
    rst = 1'b1;
    cyc();
    chk("rst_ctl", int'(act_ctl(0)), 0);
    chk("rst_req", int'(ifa.mem_req_o), 0);
    chk("rst_scnt", int'(ifa.stall_cnt_o), 0);
    cyc();
    rst = 1'b0;
    start = 1'b1;
    repeat (3) cyc();
    chk("idle_ctl", int'(act_ctl(0)), 0);
    chk("idle_cnt", int'(ifa.stall_cnt_o), 0);

    lu = 1'b1;
    br = 1'b1;
    #1;
    chk("lu_ctl", int'(act_ctl(0)), 6'b110100);
    cyc();
    lu = 1'b0;
    chk("lu_scnt", int'(ifa.stall_cnt_o), 1);
    #1;
    chk("br_flush", int'(ifa.IF_ID_Flush_o), 1);
    cyc();
    br = 1'b0;
    chk("br_fcnt", int'(ifa.flush_cnt_o), 1);

    start = 1'b0;
    repeat (3) cyc();
    chk("stop_ctl", int'(act_ctl(0)), 6'b110010);
    chk("stop_scnt", int'(ifa.stall_cnt_o), 1);
    start = 1'b1;

    do_reset();
    acc = 1'b1;
    miss = 1'b1;
    #1;
    chk("miss_t_ctl", int'(act_ctl(0)), 6'b110011);
    chk("miss_t_req", int'(ifa.mem_req_o), 0);
    cyc();
    acc = 1'b0;
    miss = 1'b0;
    chk("miss_t1_req", int'(ifa.mem_req_o), 1);
    repeat (4) cyc();
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    chk("miss_t6_req", int'(ifa.mem_req_o), 0);
    chk("miss_t6_pc", int'(ifa.PC_Stall_o), 1);
    cyc();
    chk("miss_t7_pc", int'(ifa.PC_Stall_o), 0);
    chk("miss_t7_scnt", int'(ifa.stall_cnt_o), 7);
    chk("miss_b_tmo", int'(ifb.timeout_o), 1);

    do_reset();
    acc = 1'b1;
    miss = 1'b1;
    cyc();
    acc = 1'b0;
    miss = 1'b0;
    repeat (4) cyc();
    chk("to_b_tmo", int'(ifb.timeout_o), 1);
    chk("to_a_tmo", int'(ifa.timeout_o), 0);
    chk("to_a_req", int'(ifa.mem_req_o), 1);
    ack = 1'b1;
    cyc();
    ack = 1'b0;
    repeat (2) cyc();
    chk("err_tmo", int'(ifb.timeout_o), 1);
    chk("err_ctl", int'(act_ctl(1)), 6'b110011);
    chk("err_req", int'(ifb.mem_req_o), 0);
    do_reset();
    chk("err_clr", int'(ifb.timeout_o), 0);

    acc = 1'b1;
    miss = 1'b1;
    cyc();
    acc = 1'b0;
    miss = 1'b0;
    cyc();
    chk("mid_req", int'(ifa.mem_req_o), 1);
    rst = 1'b1;
    #1;
    chk("async_req", int'(ifa.mem_req_o), 0);
    chk("async_ctl", int'(act_ctl(0)), 0);
    chk("async_scnt", int'(ifa.stall_cnt_o), 0);
    #1;
    rst = 1'b0;
    cyc();
    chk("post_rst_ctl", int'(act_ctl(0)), 0);

    lu = 1'b1;
    repeat (20) cyc();
    lu = 1'b0;
    chk("sat_a", int'(ifa.stall_cnt_o), 15);
    chk("sat_b", int'(ifb.stall_cnt_o), 20);
    repeat (2) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
